s_core_prog_loader: RTL and testbench
=====================================

# s_core_prog_loader

Byte-stream program loader that drives the s_core setup port: instruction-memory writes, register-file preload, start PC and the `setup` level. It replaces the hand-driven setup sequence with a framed command stream from a host-side byte source (UART RX, JTAG shim). It sits between that byte source and the s_core setup inputs and holds the core in setup until a START command arrives.

## Interface
Parameters:
- `RX_W`, 8, width of the incoming byte stream (fixed at 8; parameter exists for lint only).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  incoming byte.
- `i_rx_valid`  in  1  byte valid.
- `o_rx_ready`  out  1  loader can accept a byte. A transfer occurs when valid && ready.
- `o_setup`  out  1  drives s_core `setup`. 1 = core held in load mode.
- `o_inst_mem_addr`  out  32  instruction-memory write address.
- `o_inst_mem_data`  out  32  instruction-memory write data.
- `o_inst_we`  out  1  one-cycle instruction write strobe.
- `o_load_reg_addr`  out  5  register-file preload index.
- `o_load_reg_data`  out  32  register-file preload data.
- `o_reg_we`  out  1  one-cycle register write strobe.
- `o_pc_instr_start_addr`  out  32  start PC presented to the core.
- `o_err`  out  1  sticky protocol error. Cleared only by reset.

## Operation
- Frame = command byte + payload. Multi-byte fields are little-endian (first byte → bits 7:0).
  - `0x01` INST: 4 address bytes, then 4 data bytes.
  - `0x02` REG: 1 index byte (bits 4:0 used), then 4 data bytes.
  - `0x03` START: 4 start-address bytes.
  - `0x04` HALT: no payload. Valid only in RUN.
- States:
  - IDLE: waits for a command byte.
  - GET_ADDR: INST address, START address, or REG index.
  - GET_DATA: INST or REG data.
  - WRITE: single cycle; pulses `o_inst_we` or `o_reg_we`; returns to IDLE.
  - RUN.
- START: after the 4th address byte, latch `o_pc_instr_start_addr`, drop `o_setup`, go to RUN.
- RUN:
  - Only HALT is meaningful. HALT raises `o_setup` and returns to IDLE.
  - Any other byte is consumed and ignored. It does not set `o_err`.
- Errors: set `o_err` and return to IDLE (the byte is consumed) for:
  - an unknown command byte in IDLE;
  - a REG index byte with bits 7:5 ≠ 0.
- REG index 0 is written like any other index; the core's register file ignores x0.
- A 2-bit byte counter selects the byte lane. It resets to 0 on every state entry.
- Address and data output registers hold their last written value between writes.

## Timing
- Reset values:
  - `o_setup` = 1.
  - `o_rx_ready` = 1.
  - `o_inst_we`, `o_reg_we`, `o_err` = 0.
  - All address/data outputs and `o_pc_instr_start_addr` = 0.
  - State = IDLE.
- `o_rx_ready` = 1 in IDLE, GET_ADDR, GET_DATA and RUN. It is 0 in WRITE, so at most one byte is lost per frame (none is lost if the source honours ready).
- Write strobe latency:
  - The final payload byte is accepted at edge N.
  - WRITE occupies cycle N+1: strobe is high and the address/data outputs are already stable.
  - The next command byte is accepted at edge N+2 at the earliest.
  - Maximum throughput: one INST frame per 10 cycles.
- START: `o_setup` falls at the edge that accepts the 4th address byte. `o_pc_instr_start_addr` is valid at that same edge.
- HALT: `o_setup` rises at the edge that accepts it.
- `i_rx_valid` low mid-frame stalls the frame indefinitely. There is no timeout.
- Reset mid-frame:
  - The partial frame is discarded.
  - No strobe is issued.
  - `o_setup` returns to 1 on the next cycle.

## Structure
- Shared package `s_core_loader_pkg` holds:
  - command opcodes `CMD_INST`, `CMD_REG`, `CMD_START`, `CMD_HALT`;
  - the state enumeration.
- One sub-module: `byte_word_assembler`, a 32-bit little-endian shift-in register with lane counter, load enable and clear.
- The remainder (FSM, output registers) lives in `s_core_prog_loader`.

## Test plan
- Send INST frame: `01 04 00 00 00 13 74 12 00`.
  - Expect one `o_inst_we` pulse with addr=0x00000004 and data=0x00127413.
  - `o_setup` stays 1.
- Send REG frame: `02 06 01 00 00 00`.
  - Expect one `o_reg_we` pulse with addr=6 and data=0x00000001.
- Send START frame: `03 04 00 00 00`.
  - Expect `o_setup` to fall on the 4th address byte, with `o_pc_instr_start_addr`=0x00000004.
  - Then send `55`: no change, `o_err`=0.
  - Then send `04`: expect `o_setup`=1.
- Send unknown command `7F`.
  - Expect `o_err`=1 and a return to IDLE.
  - A following valid INST frame still writes correctly; `o_err` stays 1.
- Apply `rst` after 3 INST data bytes.
  - Expect no strobe and all outputs at their reset values.
  - A fresh full frame then writes correctly.
- Hold `i_rx_valid` high continuously through two back-to-back INST frames.
  - Expect `o_rx_ready` low for exactly one cycle after each frame.
  - Expect two strobes with the correct values.

Source files
------------

// File: rtl/s_core_loader_pkg.sv
// s_core_loader_pkg
// Shared definitions for the s_core program loader: the command opcodes
// carried in the first byte of each frame, the loader FSM state encoding,
// and the kind of frame currently being assembled.
// No ports (package).
package s_core_loader_pkg;

    // Command opcodes (first byte of every frame)
    localparam logic [7:0] CMD_INST  = 8'h01;
    localparam logic [7:0] CMD_REG   = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_HALT  = 8'h04;

    // Loader FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;

    // Which command opened the frame in flight
    typedef enum logic [1:0] {
        FR_INST  = 2'd0,
        FR_REG   = 2'd1,
        FR_START = 2'd2
    } frame_e;

endpackage

// File: rtl/s_core_prog_loader_byte_word_assembler.sv
// byte_word_assembler
// 32-bit little-endian shift-in register. Each loaded byte enters at the top
// and the word shifts down, so after four loads the first byte sits in
// bits 7:0. A 2-bit lane counter tracks how many bytes have arrived.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_clr         clear word and lane counter (wins over i_load)
//   i_load        shift i_byte in
//   i_byte        incoming byte
//   o_lane        index of the byte lane the next load fills
//   o_word_nxt    word as it will look once i_byte is shifted in; lets the
//                 caller latch a completed word at the edge of the 4th byte
module byte_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_lane,
    output logic [31:0] o_word_nxt
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;

    always_comb begin
        o_word_nxt = {i_byte, word_q[31:8]};
        word_d     = word_q;
        lane_d     = lane_q;
        if (i_clr) begin
            word_d = '0;
            lane_d = '0;
        end else if (i_load) begin
            word_d = o_word_nxt;
            lane_d = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign o_lane = lane_q;

endmodule

// File: rtl/s_core_prog_loader.sv
// s_core_prog_loader
// Parses a framed byte stream (command byte + little-endian payload) and
// drives the s_core setup port: instruction-memory writes, register preload,
// start PC and the setup level. The core is held in setup until START.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_rx_data/valid, o_rx_ready   byte stream in (transfer on valid && ready)
//   o_setup                  1 = core held in load mode
//   o_inst_mem_addr/data, o_inst_we   instruction write, one-cycle strobe
//   o_load_reg_addr/data, o_reg_we    register preload, one-cycle strobe
//   o_pc_instr_start_addr    start PC latched by START
//   o_err                    sticky protocol error, cleared only by reset
module s_core_prog_loader
    import s_core_loader_pkg::*;
#(
    parameter int RX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RX_W-1:0] i_rx_data,
    input  logic            i_rx_valid,
    output logic            o_rx_ready,
    output logic            o_setup,
    output logic [31:0]     o_inst_mem_addr,
    output logic [31:0]     o_inst_mem_data,
    output logic            o_inst_we,
    output logic [4:0]      o_load_reg_addr,
    output logic [31:0]     o_load_reg_data,
    output logic            o_reg_we,
    output logic [31:0]     o_pc_instr_start_addr,
    output logic            o_err
);

    logic [2:0]  state_q, state_d;
    frame_e      kind_q, kind_d;
    logic [31:0] addr_hold_q, addr_hold_d;   // INST address awaiting its data
    logic [4:0]  idx_hold_q, idx_hold_d;     // REG index awaiting its data
    logic [31:0] inst_addr_q, inst_addr_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        inst_we_q, inst_we_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_data_q, reg_data_d;
    logic        reg_we_q, reg_we_d;
    logic [31:0] pc_q, pc_d;
    logic        setup_q, setup_d;
    logic        err_q, err_d;

    logic        rx_ready;
    logic        accept;
    logic        asm_load;
    logic        asm_clr;
    logic [1:0]  lane;
    logic [31:0] word_nxt;
    logic [7:0]  rx_byte;

    assign rx_byte  = i_rx_data[7:0];
    // WRITE is the only state that refuses a byte
    assign rx_ready = (state_q != ST_WRITE);
    assign accept   = i_rx_valid && rx_ready;
    assign asm_load = accept && ((state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA));
    // Lane counter restarts on every state entry
    assign asm_clr  = (state_d != state_q);

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (asm_clr),
        .i_load     (asm_load),
        .i_byte     (rx_byte),
        .o_lane     (lane),
        .o_word_nxt (word_nxt)
    );

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_hold_d = addr_hold_q;
        idx_hold_d  = idx_hold_q;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        inst_we_d   = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        reg_we_d    = 1'b0;
        pc_d        = pc_q;
        setup_d     = setup_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_byte)
                        CMD_INST: begin
                            kind_d  = FR_INST;
                            state_d = ST_GET_ADDR;
                        end
                        CMD_REG: begin
                            kind_d  = FR_REG;
                            state_d = ST_GET_ADDR;
                        end
                        CMD_START: begin
                            kind_d  = FR_START;
                            state_d = ST_GET_ADDR;
                        end
                        // HALT outside RUN is treated as a protocol error
                        default: err_d = 1'b1;
                    endcase
                end
            end

            ST_GET_ADDR: begin
                if (accept) begin
                    if (kind_q == FR_REG) begin
                        if (rx_byte[7:5] != 3'b000) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_hold_d = rx_byte[4:0];
                            state_d    = ST_GET_DATA;
                        end
                    end else if (lane == 2'd3) begin
                        if (kind_q == FR_START) begin
                            // PC and setup change at the edge taking the 4th byte
                            pc_d    = word_nxt;
                            setup_d = 1'b0;
                            state_d = ST_RUN;
                        end else begin
                            addr_hold_d = word_nxt;
                            state_d     = ST_GET_DATA;
                        end
                    end
                end
            end

            ST_GET_DATA: begin
                if (accept && (lane == 2'd3)) begin
                    // Outputs and strobe settle at this edge so the WRITE cycle
                    // presents a stable, complete write to the core
                    state_d = ST_WRITE;
                    if (kind_q == FR_INST) begin
                        inst_addr_d = addr_hold_q;
                        inst_data_d = word_nxt;
                        inst_we_d   = 1'b1;
                    end else begin
                        reg_addr_d = idx_hold_q;
                        reg_data_d = word_nxt;
                        reg_we_d   = 1'b1;
                    end
                end
            end

            ST_WRITE: state_d = ST_IDLE;

            ST_RUN: begin
                // Everything except HALT is swallowed silently
                if (accept && (rx_byte == CMD_HALT)) begin
                    setup_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= FR_INST;
            addr_hold_q <= '0;
            idx_hold_q  <= '0;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            inst_we_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            reg_we_q    <= 1'b0;
            pc_q        <= '0;
            setup_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_hold_q <= addr_hold_d;
            idx_hold_q  <= idx_hold_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            inst_we_q   <= inst_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            reg_we_q    <= reg_we_d;
            pc_q        <= pc_d;
            setup_q     <= setup_d;
            err_q       <= err_d;
        end
    end

    assign o_rx_ready            = rx_ready;
    assign o_setup               = setup_q;
    assign o_inst_mem_addr       = inst_addr_q;
    assign o_inst_mem_data       = inst_data_q;
    assign o_inst_we             = inst_we_q;
    assign o_load_reg_addr       = reg_addr_q;
    assign o_load_reg_data       = reg_data_q;
    assign o_reg_we              = reg_we_q;
    assign o_pc_instr_start_addr = pc_q;
    assign o_err                 = err_q;

endmodule

// File: tb/tb_s_core_prog_loader.sv
module tb_s_core_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready, o_setup, o_inst_we, o_reg_we, o_err;
  logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_instr_start_addr;
  logic [4:0]  o_load_reg_addr;

  always #5 clk = ~clk;

  s_core_prog_loader #(.RX_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_setup(o_setup),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data), .o_inst_we(o_inst_we),
    .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data), .o_reg_we(o_reg_we),
    .o_pc_instr_start_addr(o_pc_instr_start_addr), .o_err(o_err)
  );

  int n_chk = 0, n_fail = 0;
  bit gaps = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level parser over a byte buffer
  bit          m_setup, m_err, m_run;
  logic [31:0] m_pc, m_ia, m_id, m_rd;
  logic [4:0]  m_ra;
  int          m_pend;             // 0 none, 1 inst write due, 2 reg write due
  int          exp_inst, exp_reg, got_inst, got_reg;
  logic [7:0]  fb[$];

  function automatic logic [31:0] le(int o);
    return {fb[o+3], fb[o+2], fb[o+1], fb[o]};
  endfunction

  task automatic model_reset();
    m_setup = 1; m_err = 0; m_run = 0; m_pc = 0;
    m_ia = 0; m_id = 0; m_ra = 0; m_rd = 0; m_pend = 0;
    fb.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    if (m_run) begin
      if (b == 8'h04) begin m_run = 0; m_setup = 1; end
      return;
    end
    if (fb.size() == 0) begin
      if (b >= 8'h01 && b <= 8'h03) fb.push_back(b);
      else m_err = 1;
      return;
    end
    fb.push_back(b);
    if (fb[0] == 8'h02 && fb.size() == 2 && b[7:5] != 3'b000) begin
      m_err = 1; fb.delete(); return;
    end
    need = (fb[0] == 8'h01) ? 9 : (fb[0] == 8'h02) ? 6 : 5;
    if (fb.size() == need) begin
      case (fb[0])
        8'h01: begin m_ia = le(1); m_id = le(5); m_pend = 1; exp_inst++; end
        8'h02: begin m_ra = fb[1][4:0]; m_rd = le(2); m_pend = 2; exp_reg++; end
        default: begin m_pc = le(1); m_setup = 0; m_run = 1; end
      endcase
      fb.delete();
    end
  endtask

  task automatic check_outputs();
    if (o_inst_we) got_inst++;
    if (o_reg_we) got_reg++;
    chk("rx_ready", o_rx_ready, m_pend == 0);
    chk("inst_we", o_inst_we, m_pend == 1);
    chk("reg_we", o_reg_we, m_pend == 2);
    chk("inst_addr", o_inst_mem_addr, m_ia);
    chk("inst_data", o_inst_mem_data, m_id);
    chk("reg_addr", o_load_reg_addr, m_ra);
    chk("reg_data", o_load_reg_data, m_rd);
    chk("setup", o_setup, m_setup);
    chk("pc", o_pc_instr_start_addr, m_pc);
    chk("err", o_err, m_err);
    m_pend = 0;
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge
  task automatic step(input logic v, input logic [7:0] b, output bit acc);
    i_rx_valid = v;
    i_rx_data  = b;
    acc = v && o_rx_ready;
    @(posedge clk);
    if (acc) model_byte(b);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int tries;
    if (gaps && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom), acc);
    acc = 0;
    tries = 0;
    while (!acc && tries < 8) begin
      step(1'b1, b, acc);
      tries++;
    end
    if (!acc) chk("rx_accept_timeout", 0, 1);
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 8'h00, acc);
  endtask

  task automatic do_reset();
    i_rx_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 0;
  endtask

  task automatic push32(inout bq_t q, input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
  endtask

  initial begin
    bq_t f;
    logic [7:0] b;
    int r;
    i_rx_data = 0; i_rx_valid = 0; rst = 1;
    exp_inst = 0; exp_reg = 0; got_inst = 0; got_reg = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed frames
    f = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h74, 8'h12, 8'h00};
    send_q(f); idle(2);
    f = '{8'h02, 8'h06, 8'h01, 8'h00, 8'h00, 8'h00};
    send_q(f); idle(2);
    f = '{8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    send_q(f);
    chk("start_setup_low", o_setup, 0);
    chk("start_pc", o_pc_instr_start_addr, 32'h4);
    send_byte(8'h55); idle(1);
    chk("run_ignore_err", o_err, 0);
    send_byte(8'h04);
    chk("halt_setup_high", o_setup, 1);
    send_byte(8'h7F);
    chk("unknown_err", o_err, 1);
    f = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q(f); idle(1);

    // Reset in the middle of an INST data phase
    f = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send_q(f);
    do_reset();
    idle(2);
    f = '{8'h01, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_q(f); idle(1);

    // Back-to-back INST frames with valid held high
    gaps = 0;
    f = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
          8'h01, 8'h24, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_q(f);
    idle(2);
    gaps = 1;

    // Randomized frames
    for (int k = 0; k < 80; k++) begin
      f.delete();
      r = $urandom_range(0, 9);
      if (r <= 3 || r >= 8) begin
        f.push_back(8'h01); push32(f, $urandom); push32(f, $urandom);
      end else if (r <= 5) begin
        f.push_back(8'h02);
        b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {3'b000, 5'($urandom)};
        f.push_back(b);
        if (b[7:5] == 3'b000) push32(f, $urandom);
      end else if (r == 6) begin
        f.push_back(8'h03); push32(f, $urandom);
        repeat ($urandom_range(0, 3)) begin
          b = 8'($urandom);
          if (b == 8'h04) b = 8'h55;
          f.push_back(b);
        end
        f.push_back(8'h04);
      end else begin
        b = 8'($urandom_range(5, 255));
        if ($urandom_range(0, 7) == 0) b = 8'h00;
        f.push_back(b);
      end
      send_q(f);
    end
    idle(3);

    chk("inst_strobe_count", got_inst, exp_inst);
    chk("reg_strobe_count", got_reg, exp_reg);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
